// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction-memory port, EX redirect, and the IF/ID slot
// handed to decode. master = fetch stage, slave = memory/EX/decode side.
interface pc_fetch_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      imem_addr;
  logic [31:0]      imem_instr;
  logic             redirect_vld;
  logic [31:0]      redirect_pc;
  logic             id_ready;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic [31:0]      if_pc4;
  logic             if_fault;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc4, if_fault, fetch_cnt,
    input  imem_instr, redirect_vld, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc4, if_fault, fetch_cnt,
    output imem_instr, redirect_vld, redirect_pc, id_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, combinational imem address, and a
// registered IF/ID slot with valid/ready toward decode, redirect flush and fault slots.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int          CNT_W      = 32
) (
  input logic       clk,
  input logic       rst,
  pc_fetch_if.master bus
);
  localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } slot_t;

  slot_t            slot_q, slot_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire, load, oob;

  assign fire = slot_q.valid & bus.id_ready;
  assign load = ~slot_q.valid | bus.id_ready;
  assign oob  = {2'b00, pc_q[31:2]} >= IMEM_WORDS_W;

  always_comb begin
    slot_d     = slot_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cnt_d      = (fire && cnt_q != '1) ? cnt_q + CNT_ONE : cnt_q;
    if (bus.redirect_vld) begin
      // Flush wins over a same-cycle fire; the fire itself is still counted above.
      pc_d         = {bus.redirect_pc[31:2], 2'b00};
      misalign_d   = |bus.redirect_pc[1:0];
      slot_d.valid = 1'b0;
      slot_d.fault = 1'b0;
    end else if (load) begin
      slot_d.valid = 1'b1;
      slot_d.pc    = pc_q;
      slot_d.pc4   = pc_q + 32'd4;
      if (misalign_q || oob) begin
        // Fault slot repeats until a redirect: pc is parked, decode sees a nop.
        slot_d.fault = 1'b1;
        slot_d.instr = 32'h0000_0000;
      end else begin
        slot_d.fault = 1'b0;
        slot_d.instr = bus.imem_instr;
        pc_d         = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      slot_q     <= slot_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = slot_q.valid;
  assign bus.if_fault  = slot_q.fault;
  assign bus.if_instr  = slot_q.instr;
  assign bus.if_pc     = slot_q.pc;
  assign bus.if_pc4    = slot_q.pc4;
  assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: expected fired slots go into a scoreboard queue,
// a negedge monitor pops and compares on every handshake; state checks are inline.
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_if #(.CNT_W(32)) bus ();

  pc_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: word k holds value k.
  always_comb bus.imem_instr = {2'b00, bus.imem_addr[31:2]};

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    exp_t e;
    e.pc = pc; e.instr = instr; e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every slot decode accepts must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid && bus.id_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow_pc", bus.if_pc, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", bus.if_pc, e.pc);
          chk("sb_pc4", bus.if_pc4, e.pc + 32'd4);
          chk("sb_instr", bus.if_instr, e.instr);
          chk("sb_fault", {31'd0, bus.if_fault}, {31'd0, e.fault});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.id_ready     = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_fault", {31'd0, bus.if_fault}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_pc4", bus.if_pc4, 32'd0);
    chk("rst_cnt", bus.fetch_cnt, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);

    // Streaming fetch
    rst = 1'b0; bus.id_ready = 1'b1;
    push(32'h0, 32'd0, 1'b0); push(32'h4, 32'd1, 1'b0); push(32'h8, 32'd2, 1'b0);
    step();
    chk("stream_addr", bus.imem_addr, 32'h4);
    step(); step();
    bus.id_ready = 1'b0;
    chk("stream_cnt2", bus.fetch_cnt, 32'd2);

    // Stall holding slot at pc 8
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.if_pc, 32'h8);
      chk("stall_instr", bus.if_instr, 32'd2);
      chk("stall_addr", bus.imem_addr, 32'hC);
    end
    bus.id_ready = 1'b1;
    push(32'hC, 32'd3, 1'b0);
    step();
    chk("cnt_after3", bus.fetch_cnt, 32'd3);
    step();

    // Redirect to 0x40 while decode stalled
    bus.id_ready = 1'b0; bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h40;
    step();
    bus.redirect_vld = 1'b0;
    chk("redir_flush", {31'd0, bus.if_valid}, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h40);
    chk("redir_cnt", bus.fetch_cnt, 32'd4);
    step();
    chk("redir_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("redir_pc", bus.if_pc, 32'h40);
    chk("redir_instr", bus.if_instr, 32'h10);
    chk("redir_next_addr", bus.imem_addr, 32'h44);

    // Misaligned redirect in the same cycle as a fire
    bus.id_ready = 1'b1; bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h42;
    push(32'h40, 32'h10, 1'b0);
    step();
    bus.redirect_vld = 1'b0; bus.id_ready = 1'b0;
    chk("mis_cnt", bus.fetch_cnt, 32'd5);
    chk("mis_flush", {31'd0, bus.if_valid}, 32'd0);
    chk("mis_addr", bus.imem_addr, 32'h40);
    step();
    chk("mis_fault", {31'd0, bus.if_fault}, 32'd1);
    chk("mis_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("mis_instr", bus.if_instr, 32'd0);
    chk("mis_pc", bus.if_pc, 32'h40);
    step();
    bus.id_ready = 1'b1;
    push(32'h40, 32'd0, 1'b1); push(32'h40, 32'd0, 1'b1);
    step(); step();
    bus.id_ready = 1'b0;
    chk("mis_hold_addr", bus.imem_addr, 32'h40);
    chk("mis_cnt2", bus.fetch_cnt, 32'd7);
    bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h10;
    step();
    bus.redirect_vld = 1'b0;
    chk("clr_fault", {31'd0, bus.if_fault}, 32'd0);
    step();
    chk("clr_pc", bus.if_pc, 32'h10);
    chk("clr_instr", bus.if_instr, 32'h4);
    chk("clr_fault2", {31'd0, bus.if_fault}, 32'd0);

    // Run off the end of instruction memory
    bus.redirect_vld = 1'b1; bus.redirect_pc = 32'hFF8;
    step();
    bus.redirect_vld = 1'b0; bus.id_ready = 1'b1;
    push(32'hFF8, 32'd1022, 1'b0); push(32'hFFC, 32'd1023, 1'b0);
    step(); step(); step();
    bus.id_ready = 1'b0;
    chk("oob_fault", {31'd0, bus.if_fault}, 32'd1);
    chk("oob_instr", bus.if_instr, 32'd0);
    chk("oob_pc", bus.if_pc, 32'h1000);
    chk("oob_addr", bus.imem_addr, 32'h1000);
    chk("oob_cnt", bus.fetch_cnt, 32'd9);
    step();
    chk("oob_addr_hold", bus.imem_addr, 32'h1000);

    // Reset mid-stall
    rst = 1'b1;
    step();
    chk("rst2_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst2_fault", {31'd0, bus.if_fault}, 32'd0);
    chk("rst2_cnt", bus.fetch_cnt, 32'd0);
    chk("rst2_addr", bus.imem_addr, 32'd0);
    rst = 1'b0; bus.id_ready = 1'b1;
    push(32'h0, 32'd0, 1'b0);
    step();
    #6;
    bus.id_ready = 1'b0;
    step(); step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
